// File: rtl/bsg_cache_trace_driver_32.sv
// rtl/bsg_cache_trace_driver_32.sv - replays a trace ROM into the bsg_cache request port
// Bounds in-flight requests, consumes every response and flags completion once drained.
module bsg_cache_trace_driver_32
  #(parameter int data_width_p      = 32
   ,parameter int addr_width_p      = 30
   ,parameter int rom_els_p         = 256
   ,parameter int max_outstanding_p = 4
   ,localparam int cache_pkt_width_lp = 6 + addr_width_p + data_width_p + (data_width_p/8)
   ,localparam int rom_width_lp       = cache_pkt_width_lp + 1
   ,localparam int rom_addr_width_lp  = $clog2(rom_els_p)
  )
  (input  logic                          clk_i
  ,input  logic                          reset_i
  ,input  logic                          en_i
  ,output logic [rom_addr_width_lp-1:0]  rom_addr_o
  ,input  logic [rom_width_lp-1:0]       rom_data_i
  ,output logic [cache_pkt_width_lp-1:0] cache_pkt_o
  ,output logic                          v_o
  ,input  logic                          yumi_i
  ,input  logic [data_width_p-1:0]       data_i
  ,input  logic                          v_i
  ,output logic                          yumi_o
  ,output logic [31:0]                   sent_count_o
  ,output logic [31:0]                   recv_count_o
  ,output logic                          done_o
  );

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);

  localparam logic [1:0] SEND  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [out_width_lp-1:0]      max_out_lp   = out_width_lp'(max_outstanding_p);
  localparam logic [rom_addr_width_lp-1:0] last_addr_lp = rom_addr_width_lp'(rom_els_p - 1);

  logic [1:0]                   state_q, state_d;
  logic [rom_addr_width_lp-1:0] addr_q, addr_d;
  logic [out_width_lp-1:0]      out_q, out_d;
  logic [31:0]                  sent_q, sent_d;
  logic [31:0]                  recv_q, recv_d;
  logic                         accept;
  logic                         last_bit;

  // Response data is only observed by the checker side of the testbench.
  logic unused_data;
  assign unused_data = ^data_i;

  assign last_bit     = rom_data_i[rom_width_lp-1];
  assign cache_pkt_o  = rom_data_i[cache_pkt_width_lp-1:0];
  assign rom_addr_o   = addr_q;
  assign sent_count_o = sent_q;
  assign recv_count_o = recv_q;
  assign done_o       = (state_q == DONE);

  assign v_o    = ~reset_i & (state_q == SEND) & en_i & (out_q < max_out_lp);
  assign yumi_o = v_i & ~reset_i;
  assign accept = v_o & yumi_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    out_d   = out_q;
    sent_d  = sent_q + 32'(accept);
    recv_d  = recv_q + 32'(yumi_o);

    // An unexpected response at zero outstanding leaves the counter at zero.
    if (accept && !yumi_o)
      out_d = out_q + 1'b1;
    else if (!accept && yumi_o && (out_q != '0))
      out_d = out_q - 1'b1;

    case (state_q)
      SEND: begin
        if (accept) begin
          if (last_bit || (addr_q == last_addr_lp))
            state_d = DRAIN;
          else
            addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_d == '0)
          state_d = DONE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SEND;
      addr_q  <= '0;
      out_q   <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (yumi_i && !v_o)
        $error("bsg_cache_trace_driver_32: yumi_i asserted without v_o");
      if (v_i && (out_q == '0) && !accept)
        $error("bsg_cache_trace_driver_32: response with nothing outstanding");
    end
  end

endmodule

// File: tb/tb_bsg_cache_trace_driver_32.sv
// tb/tb_bsg_cache_trace_driver_32.sv - directed bench for bsg_cache_trace_driver_32
// Acts as trace ROM and cache; ROM contents are rewritten between scenarios.
module tb_bsg_cache_trace_driver_32;

  localparam int PW = 72;
  localparam int RW = 73;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_i, en_i, yumi_i, v_i;
  logic [AW-1:0] rom_addr_o;
  logic [RW-1:0] rom_data_i;
  logic [PW-1:0] cache_pkt_o;
  logic          v_o, yumi_o, done_o;
  logic [31:0]   data_i, sent_count_o, recv_count_o;

  logic [RW-1:0] rom [8];
  int checks = 0;
  int errors = 0;

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk = ~clk;

  bsg_cache_trace_driver_32 #(.rom_els_p(8), .max_outstanding_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .cache_pkt_o(cache_pkt_o), .v_o(v_o), .yumi_i(yumi_i),
    .data_i(data_i), .v_i(v_i), .yumi_o(yumi_o), .sent_count_o(sent_count_o),
    .recv_count_o(recv_count_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic last, input logic [5:0] op,
                                       input logic [29:0] addr, input logic [31:0] data);
    return {last, op, addr, data, 4'hF};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for this cycle; the cache only accepts what is offered.
  task automatic drive(input logic en, input logic want, input logic vi);
    en_i = en;
    v_i  = vi;
    #1;
    yumi_i = v_o & want;
    #1;
  endtask

  task automatic do_reset(input logic chk);
    reset_i = 1'b1;
    en_i    = 1'b1;
    v_i     = 1'b1;
    yumi_i  = 1'b0;
    #1;
    if (chk) begin
      check("rst_v_o", v_o, 1'b0);
      check("rst_yumi_o", yumi_o, 1'b0);
    end
    tick();
    v_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  // Cache answers every accepted request exactly one cycle later.
  task automatic run_trace(output int acc_n, output int last_resp, output int done_cyc);
    logic prev;
    prev      = 1'b0;
    acc_n     = 0;
    last_resp = -1;
    done_cyc  = -1;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 1'b1, prev);
      if (done_o) begin
        done_cyc = c;
        break;
      end
      if (v_i) last_resp = c;
      prev  = yumi_i;
      acc_n = acc_n + int'(yumi_i);
      tick();
    end
    v_i    = 1'b0;
    yumi_i = 1'b0;
  endtask

  initial begin
    int acc, lr, dc;
    logic [RW-1:0] e;
    data_i = 32'h0;
    en_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; reset_i = 1'b1;

    // 5-entry trace ending in LW 0x10
    rom[0] = mk(1'b0, 6'h08, 30'h10, 32'hDEADBEEF);
    rom[1] = mk(1'b0, 6'h08, 30'h14, 32'h12345678);
    rom[2] = mk(1'b0, 6'h00, 30'h14, 32'h0);
    rom[3] = mk(1'b0, 6'h08, 30'h18, 32'hCAFEF00D);
    rom[4] = mk(1'b1, 6'h00, 30'h10, 32'h0);
    rom[5] = mk(1'b0, 6'h3F, 30'h3FFFFFFF, 32'hFFFFFFFF);
    rom[6] = rom[5];
    rom[7] = rom[5];
    do_reset(1'b1);
    check("rst_addr", rom_addr_o, 3'd0);
    check("rst_sent", sent_count_o, 32'd0);
    check("rst_recv", recv_count_o, 32'd0);
    check("rst_done", done_o, 1'b0);
    check("t1_pkt0", cache_pkt_o, {6'h08, 30'h10, 32'hDEADBEEF, 4'hF});
    run_trace(acc, lr, dc);
    check("t1_accepts", acc, 5);
    check("t1_last_resp", lr, 5);
    check("t1_done_cyc", dc, 6);
    check("t1_sent", sent_count_o, 32'd5);
    check("t1_recv", recv_count_o, 32'd5);
    check("t1_addr_held", rom_addr_o, 3'd4);

    // No last bit anywhere: responses withheld against the outstanding limit
    for (int i = 0; i < 8; i++) rom[i] = mk(1'b0, 6'h08, 30'(i * 4), 32'(i + 100));
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      check("t2_v_fill", v_o, 1'b1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    check("t2_v_full", v_o, 1'b0);
    check("t2_sent4", sent_count_o, 32'd4);
    check("t2_addr4", rom_addr_o, 3'd4);
    tick();
    drive(1'b1, 1'b1, 1'b1);
    check("t2_v_full2", v_o, 1'b0);
    check("t2_yumi_o", yumi_o, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    check("t2_v_release", v_o, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    check("t2_v_refull", v_o, 1'b0);
    check("t2_sent5", sent_count_o, 32'd5);
    check("t2_recv1", recv_count_o, 32'd1);

    // Full 8-entry ROM without a last bit
    do_reset(1'b0);
    run_trace(acc, lr, dc);
    check("t4_accepts", acc, 8);
    check("t4_done_cyc", dc, lr + 1);
    check("t4_sent", sent_count_o, 32'd8);
    check("t4_recv", recv_count_o, 32'd8);
    check("t4_addr_held", rom_addr_o, 3'd7);

    // Backpressure and enable hold
    do_reset(1'b0);
    e = mk(1'b0, 6'h08, 30'h0, 32'd100);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b0);
      check("t3_v_hold", v_o, 1'b1);
      check("t3_addr_hold", rom_addr_o, 3'd0);
      check("t3_pkt_hold", cache_pkt_o, e[PW-1:0]);
      check("t3_sent_hold", sent_count_o, 32'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    tick();
    e = mk(1'b0, 6'h08, 30'h4, 32'd101);
    check("t3_addr1", rom_addr_o, 3'd1);
    check("t3_sent1", sent_count_o, 32'd1);
    check("t3_pkt1", cache_pkt_o, e[PW-1:0]);
    drive(1'b0, 1'b1, 1'b0);
    check("t3_en_low_v", v_o, 1'b0);
    tick();
    check("t3_en_addr", rom_addr_o, 3'd1);
    check("t3_en_sent", sent_count_o, 32'd1);

    // Same-cycle accept and response at outstanding=2
    do_reset(1'b0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1);
    check("t5_v_both", v_o, 1'b1);
    tick();
    check("t5_sent3", sent_count_o, 32'd3);
    check("t5_recv1", recv_count_o, 32'd1);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      acc = acc + int'(yumi_i);
      tick();
    end
    check("t5_extra_accepts", acc, 2);

    // Reset mid-trace
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    check("t6_pre_sent", sent_count_o, 32'd3);
    do_reset(1'b0);
    check("t6_addr", rom_addr_o, 3'd0);
    check("t6_sent", sent_count_o, 32'd0);
    check("t6_recv", recv_count_o, 32'd0);
    check("t6_done", done_o, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("t6_restart_addr", rom_addr_o, 3'd1);
    check("t6_restart_sent", sent_count_o, 32'd1);

    // First entry already carries the last bit
    rom[0] = mk(1'b1, 6'h00, 30'h20, 32'h0);
    do_reset(1'b0);
    run_trace(acc, lr, dc);
    check("t7_accepts", acc, 1);
    check("t7_done_cyc", dc, 2);
    check("t7_addr", rom_addr_o, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
